// File: rtl/asrv32_pkg.sv
// asrv32 register-file scheduler shared definitions.
// Address/data widths, requester ids, writeback bundle.
package asrv32_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/asrv32_wb_arbiter.sv
// Two-requester write-port arbiter (ALU/LSU).
// Round-robin or LSU-priority grant plus write mux.
module asrv32_wb_arbiter
   import asrv32_pkg::*;
#(
   parameter int RR_ARB = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  wb_req_t               alu,
   input  wb_req_t               lsu,
   output logic                  alu_ready,
   output logic                  lsu_ready,
   output logic                  ce_wr,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]       rd_data
);

   logic rr_ptr;
   logic contest;
   logic gnt_alu;
   logic gnt_lsu;

   // grant: lone requester wins, contest resolved by pointer or LSU
   always_comb begin
      contest = alu.valid & lsu.valid;
      gnt_alu = alu.valid & ~lsu.valid;
      gnt_lsu = lsu.valid & ~alu.valid;
      if (contest) begin
         if (RR_ARB != 0 && rr_ptr == REQ_ALU) gnt_alu = 1'b1;
         else gnt_lsu = 1'b1;
      end
   end

   // write mux toward the register file
   always_comb begin
      alu_ready = gnt_alu;
      lsu_ready = gnt_lsu;
      ce_wr     = 1'b0;
      rd_addr   = '0;
      rd_data   = '0;
      unique case (1'b1)
         gnt_alu: begin
            ce_wr   = |alu.rd;
            rd_addr = alu.rd;
            rd_data = alu.data;
         end
         gnt_lsu: begin
            ce_wr   = |lsu.rd;
            rd_addr = lsu.rd;
            rd_data = lsu.data;
         end
         default: ;
      endcase
   end

   // pointer flips only after a contested grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr <= REQ_ALU;
      else if (contest && RR_ARB != 0) rr_ptr <= ~rr_ptr;
   end

endmodule

// File: rtl/asrv32_regfile_sched.sv
// Issue/writeback scheduler in front of the register file.
// Busy-bit scoreboard gates issue; arbiter owns the write port.
module asrv32_regfile_sched
   import asrv32_pkg::*;
#(
   parameter int MAX_OUT = 4,
   parameter int RR_ARB  = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_iss_valid,
   output logic                  o_iss_ready,
   input  logic [REG_ADDR_W-1:0] i_iss_rs1,
   input  logic [REG_ADDR_W-1:0] i_iss_rs2,
   input  logic [REG_ADDR_W-1:0] i_iss_rd,
   input  logic                  i_iss_wr,
   output logic                  o_ce_rd,
   output logic [REG_ADDR_W-1:0] o_rs1_addr,
   output logic [REG_ADDR_W-1:0] o_rs2_addr,
   output logic                  o_rdata_valid,
   input  logic                  i_alu_valid,
   output logic                  o_alu_ready,
   input  logic [REG_ADDR_W-1:0] i_alu_rd,
   input  logic [XLEN-1:0]       i_alu_data,
   input  logic                  i_lsu_valid,
   output logic                  o_lsu_ready,
   input  logic [REG_ADDR_W-1:0] i_lsu_rd,
   input  logic [XLEN-1:0]       i_lsu_data,
   output logic                  o_ce_wr,
   output logic [REG_ADDR_W-1:0] o_rd_addr,
   output logic [XLEN-1:0]       o_rd_data
);

   localparam logic [5:0] MAX_C = 6'(MAX_OUT);

   logic [31:0] busy;
   logic [31:0] busy_nxt;
   logic [5:0]  out_cnt;
   logic [5:0]  cnt_nxt;
   logic        rdv;
   logic        full;
   logic        sb_set;
   logic        sb_clr;
   wb_req_t     alu_req;
   wb_req_t     lsu_req;

   assign alu_req = '{valid: i_alu_valid, rd: i_alu_rd, data: i_alu_data};
   assign lsu_req = '{valid: i_lsu_valid, rd: i_lsu_rd, data: i_lsu_data};

   assign full = (out_cnt == MAX_C);

   assign o_iss_ready = ~busy[i_iss_rs1] & ~busy[i_iss_rs2]
                      & ~(i_iss_wr & busy[i_iss_rd])
                      & ~(i_iss_wr & (|i_iss_rd) & full);

   assign o_ce_rd       = i_iss_valid & o_iss_ready;
   assign o_rs1_addr    = i_iss_rs1;
   assign o_rs2_addr    = i_iss_rs2;
   assign o_rdata_valid = rdv;

   asrv32_wb_arbiter #(
      .RR_ARB (RR_ARB)
   ) u_arb (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .alu       (alu_req),
      .lsu       (lsu_req),
      .alu_ready (o_alu_ready),
      .lsu_ready (o_lsu_ready),
      .ce_wr     (o_ce_wr),
      .rd_addr   (o_rd_addr),
      .rd_data   (o_rd_data)
   );

   // scoreboard next state: clear on write to a busy reg, set on issue
   always_comb begin
      sb_set   = o_ce_rd & i_iss_wr & (|i_iss_rd);
      sb_clr   = o_ce_wr & busy[o_rd_addr];
      busy_nxt = busy;
      if (sb_clr) busy_nxt[o_rd_addr] = 1'b0;
      if (sb_set) busy_nxt[i_iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
      cnt_nxt = out_cnt + {5'd0, sb_set} - {5'd0, sb_clr};
   end

   // scoreboard, outstanding count and read-valid registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy    <= '0;
         out_cnt <= '0;
         rdv     <= 1'b0;
      end else begin
         busy    <= busy_nxt;
         out_cnt <= cnt_nxt;
         rdv     <= o_ce_rd;
      end
   end

   // a writeback to a register that is not busy means lost tracking
   wb_busy_chk: assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      !(o_ce_wr && !busy[o_rd_addr])
   );

endmodule

// File: tb/tb_asrv32_regfile_sched.sv
// Directed bench for asrv32_regfile_sched.
// Per-cycle vector table plus reset and fixed-priority sequences.
module tb_asrv32_regfile_sched;

   logic        clk;
   logic        rst_n;
   logic        iv, wr, av, lv;
   logic [4:0]  rs1, rs2, rd, ard, lrd;
   logic [31:0] ad, ld;
   logic        rdy, cerd, rdv, ardy, lrdy, cewr;
   logic [4:0]  ra1, ra2, wa;
   logic [31:0] wd;

   logic        f_iv, f_wr, f_av, f_lv;
   logic [4:0]  f_rs1, f_rs2, f_rd, f_ard, f_lrd;
   logic [31:0] f_ad, f_ld;
   logic        f_rdy, f_cerd, f_rdv, f_ardy, f_lrdy, f_cewr;
   logic [4:0]  f_ra1, f_ra2, f_wa;
   logic [31:0] f_wd;

   int n_cmp = 0;
   int n_bad = 0;

   asrv32_regfile_sched #(.MAX_OUT(4), .RR_ARB(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_iss_valid(iv), .o_iss_ready(rdy),
      .i_iss_rs1(rs1), .i_iss_rs2(rs2),
      .i_iss_rd(rd), .i_iss_wr(wr),
      .o_ce_rd(cerd), .o_rs1_addr(ra1), .o_rs2_addr(ra2),
      .o_rdata_valid(rdv),
      .i_alu_valid(av), .o_alu_ready(ardy),
      .i_alu_rd(ard), .i_alu_data(ad),
      .i_lsu_valid(lv), .o_lsu_ready(lrdy),
      .i_lsu_rd(lrd), .i_lsu_data(ld),
      .o_ce_wr(cewr), .o_rd_addr(wa), .o_rd_data(wd)
   );

   asrv32_regfile_sched #(.MAX_OUT(4), .RR_ARB(0)) dut_fp (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_iss_valid(f_iv), .o_iss_ready(f_rdy),
      .i_iss_rs1(f_rs1), .i_iss_rs2(f_rs2),
      .i_iss_rd(f_rd), .i_iss_wr(f_wr),
      .o_ce_rd(f_cerd), .o_rs1_addr(f_ra1), .o_rs2_addr(f_ra2),
      .o_rdata_valid(f_rdv),
      .i_alu_valid(f_av), .o_alu_ready(f_ardy),
      .i_alu_rd(f_ard), .i_alu_data(f_ad),
      .i_lsu_valid(f_lv), .o_lsu_ready(f_lrdy),
      .i_lsu_rd(f_lrd), .i_lsu_data(f_ld),
      .o_ce_wr(f_cewr), .o_rd_addr(f_wa), .o_rd_data(f_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        iv;
      logic [4:0]  rs1, rs2, rd;
      logic        wr;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
      logic        e_rdy, e_cerd, e_rdv, e_ardy, e_lrdy, e_cewr;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle_main();
      iv = 0; rs1 = 0; rs2 = 0; rd = 0; wr = 0;
      av = 0; ard = 0; ad = 0; lv = 0; lrd = 0; ld = 0;
   endtask

   task automatic idle_fp();
      f_iv = 0; f_rs1 = 0; f_rs2 = 0; f_rd = 0; f_wr = 0;
      f_av = 0; f_ard = 0; f_ad = 0; f_lv = 0; f_lrd = 0; f_ld = 0;
   endtask

   initial begin
      tbl[0]  = '{1'b1,5'd1,5'd2,5'd3,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[1]  = '{1'b1,5'd3,5'd0,5'd0,1'b0, 1'b1,5'd3,32'hDEADBEEF,
                  1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,5'd3,32'hDEADBEEF};
      tbl[2]  = '{1'b1,5'd3,5'd0,5'd0,1'b0, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[3]  = '{1'b1,5'd0,5'd0,5'd5,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[4]  = '{1'b1,5'd0,5'd0,5'd6,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[5]  = '{1'b0,5'd0,5'd0,5'd0,1'b0, 1'b1,5'd5,32'h55,
                  1'b1,5'd6,32'h66, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,5'd5,32'h55};
      tbl[6]  = '{1'b0,5'd0,5'd0,5'd0,1'b0, 1'b1,5'd5,32'h77,
                  1'b1,5'd6,32'h66, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,5'd6,32'h66};
      tbl[7]  = '{1'b1,5'd0,5'd0,5'd1,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[8]  = '{1'b1,5'd0,5'd0,5'd2,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[9]  = '{1'b1,5'd0,5'd0,5'd3,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[10] = '{1'b1,5'd0,5'd0,5'd4,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[11] = '{1'b1,5'd0,5'd0,5'd7,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[12] = '{1'b1,5'd8,5'd9,5'd7,1'b0, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[13] = '{1'b1,5'd1,5'd0,5'd0,1'b0, 1'b0,5'd0,32'h0,
                  1'b1,5'd0,32'h1234, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,5'd0,32'h1234};
      tbl[14] = '{1'b1,5'd0,5'd0,5'd7,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[15] = '{1'b1,5'd1,5'd0,5'd0,1'b0, 1'b1,5'd1,32'h11,
                  1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,5'd1,32'h11};
      tbl[16] = '{1'b1,5'd1,5'd0,5'd7,1'b1, 1'b1,5'd2,32'h22,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,5'd2,32'h22};
      tbl[17] = '{1'b1,5'd0,5'd0,5'd8,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0};
      tbl[18] = '{1'b1,5'd0,5'd0,5'd9,1'b1, 1'b0,5'd0,32'h0,
                  1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0};

      // reset state
      rst_n = 1'b0;
      idle_main();
      idle_fp();
      repeat (2) @(negedge clk);
      #2;
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_ce_rd", 32'(cerd), 32'd0);
      chk("rst_rdv", 32'(rdv), 32'd0);
      chk("rst_ce_wr", 32'(cewr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // per-cycle table, state carried across rows
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         iv = tbl[i].iv; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
         rd = tbl[i].rd; wr = tbl[i].wr;
         av = tbl[i].av; ard = tbl[i].ard; ad = tbl[i].ad;
         lv = tbl[i].lv; lrd = tbl[i].lrd; ld = tbl[i].ld;
         #2;
         chk($sformatf("v%0d_ready", i), 32'(rdy), 32'(tbl[i].e_rdy));
         chk($sformatf("v%0d_ce_rd", i), 32'(cerd), 32'(tbl[i].e_cerd));
         chk($sformatf("v%0d_rdv", i), 32'(rdv), 32'(tbl[i].e_rdv));
         chk($sformatf("v%0d_alu_rdy", i), 32'(ardy), 32'(tbl[i].e_ardy));
         chk($sformatf("v%0d_lsu_rdy", i), 32'(lrdy), 32'(tbl[i].e_lrdy));
         chk($sformatf("v%0d_ce_wr", i), 32'(cewr), 32'(tbl[i].e_cewr));
         chk($sformatf("v%0d_wa", i), 32'(wa), 32'(tbl[i].e_wa));
         chk($sformatf("v%0d_wd", i), wd, tbl[i].e_wd);
         chk($sformatf("v%0d_rs1", i), 32'(ra1), 32'(tbl[i].rs1));
      end

      // fixed-priority instance: LSU wins a contested cycle
      @(negedge clk);
      idle_main();
      f_iv = 1; f_rd = 5'd5; f_wr = 1;
      @(negedge clk);
      f_rd = 5'd6;
      @(negedge clk);
      idle_fp();
      f_av = 1; f_ard = 5'd5; f_ad = 32'hA5;
      f_lv = 1; f_lrd = 5'd6; f_ld = 32'hB6;
      #2;
      chk("fp_alu_rdy", 32'(f_ardy), 32'd0);
      chk("fp_lsu_rdy", 32'(f_lrdy), 32'd1);
      chk("fp_wa", 32'(f_wa), 32'd6);
      chk("fp_wd", f_wd, 32'hB6);
      @(negedge clk);
      f_lv = 0;
      #2;
      chk("fp2_alu_rdy", 32'(f_ardy), 32'd1);
      chk("fp2_wa", 32'(f_wa), 32'd5);
      chk("fp2_wd", f_wd, 32'hA5);
      @(negedge clk);
      idle_fp();

      // async reset while stalled on busy[3] with a writeback pending
      iv = 1; rs1 = 0; rs2 = 0; rd = 0; wr = 0;
      @(negedge clk);
      iv = 1; rs1 = 5'd3; av = 1; ard = 5'd4; ad = 32'h44;
      #1;
      chk("pre_rst_ready", 32'(rdy), 32'd0);
      chk("pre_rst_rdv", 32'(rdv), 32'd1);
      #1;
      rst_n = 1'b0;
      av = 0;
      #1;
      chk("in_rst_ready", 32'(rdy), 32'd1);
      chk("in_rst_ce_rd", 32'(cerd), 32'd1);
      chk("in_rst_rdv", 32'(rdv), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      chk("post_rst_ready", 32'(rdy), 32'd1);
      chk("post_rst_ce_rd", 32'(cerd), 32'd1);
      chk("post_rst_ce_wr", 32'(cewr), 32'd0);
      @(negedge clk);
      idle_main();
      #2;
      chk("post_rst_rdv", 32'(rdv), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/asrv32_regfile_sched.md
Name: asrv32_regfile_sched

Overview:
Scheduler in front of the base register file (2 sync-read ports, 1 write port). Accepts decoded-instruction read requests and gates them through a busy-bit scoreboard (RAW/WAW stall). Arbitrates the single write port between the ALU writeback and LSU load-return requesters. Sits between decode/issue and the register file.

Parameters:
MAX_OUT, 4, max registers simultaneously marked busy (outstanding writes); range 1..31
RR_ARB, 1, 1 = round-robin between ALU and LSU on the write port; 0 = fixed priority, LSU wins

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_iss_valid  in  1  issue request valid
o_iss_ready  out  1  issue accepted this cycle when valid&ready
i_iss_rs1  in  5  source 1 address
i_iss_rs2  in  5  source 2 address
i_iss_rd  in  5  destination address
i_iss_wr  in  1  instruction writes rd
o_ce_rd  out  1  register-file read enable
o_rs1_addr  out  5  to register file
o_rs2_addr  out  5  to register file
o_rdata_valid  out  1  register-file read data valid
i_alu_valid  in  1  ALU writeback request
o_alu_ready  out  1  ALU write granted
i_alu_rd  in  5  ALU destination
i_alu_data  in  32  ALU result
i_lsu_valid  in  1  LSU writeback request
o_lsu_ready  out  1  LSU write granted
i_lsu_rd  in  5  LSU destination
i_lsu_data  in  32  load data
o_ce_wr  out  1  register-file write enable
o_rd_addr  out  5  write address
o_rd_data  out  32  write data

Behaviour:
- Reset (async, i_rst_n=0): busy[31:1]=0, out_cnt=0, rr_ptr=ALU, o_rdata_valid=0. Pending issues and writebacks are dropped. All combinational outputs evaluate from the cleared state: o_iss_ready=1, o_ce_rd=i_iss_valid.
- Scoreboard: busy[r] for r=1..31; x0 is never busy.
- o_iss_ready = !busy[rs1] & !busy[rs2] & !(i_iss_wr & busy[rd]) & !(i_iss_wr & rd!=0 & out_cnt==MAX_OUT). Computed from registered busy only; no same-cycle clear bypass, so a register freed in cycle N unblocks issue in N+1.
- o_ce_rd = i_iss_valid & o_iss_ready. o_rs1_addr/o_rs2_addr are passthrough of i_iss_rs1/i_iss_rs2.
- o_rdata_valid is a register: set 1 cycle after o_ce_rd; latency 1.
- On issue accept with i_iss_wr & rd!=0: busy[rd] <= 1 and out_cnt += 1.
- Write arbiter (combinational grant, one write per cycle):
  - only one valid: that requester is granted;
  - both valid, RR_ARB=1: rr_ptr side is granted, and rr_ptr flips to the other side after each contested grant;
  - both valid, RR_ARB=0: LSU is granted.
- Granted requester: ready=1, o_ce_wr = (rd!=0), o_rd_addr/o_rd_data are muxed from it. On grant with rd!=0: busy[rd] <= 0 and out_cnt -= 1.
- No grant: o_ce_wr=0, o_rd_addr=0, o_rd_data=0.
- rd=0 writeback: handshake completes; no write; no scoreboard change.
- Same-cycle issue set and writeback clear: counter nets to the same value. A clear and a set of the same register cannot coincide, because issue stalls on busy[rd].
- Writeback to a non-busy register: the write still occurs; scoreboard unchanged; out_cnt not decremented (saturate at 0). Flagged by a simulation-only assertion.

Decomposition:
- Package asrv32_pkg: REG_ADDR_W=5, XLEN=32, requester index constants (REQ_ALU=0, REQ_LSU=1).
- One natural sub-module: asrv32_wb_arbiter (2-requester RR/fixed arbiter plus write mux). Scoreboard and issue gating stay in the top module.

Test Plan:
- Reset released, issue rs1=1, rs2=2, rd=3, wr=1 -> o_iss_ready=1, o_ce_rd=1, next cycle o_rdata_valid=1 and busy[3]=1, out_cnt=1.
- After the above, issue rs1=3 -> o_iss_ready=0. ALU writeback rd=3, data=0xDEADBEEF -> o_ce_wr=1, o_rd_addr=3, o_rd_data=0xDEADBEEF; issue accepted the following cycle.
- ALU (rd=5) and LSU (rd=6) both valid, RR_ARB=1, rr_ptr=ALU -> ALU granted in cycle N, LSU in N+1. Repeat with RR_ARB=0 -> LSU first.
- MAX_OUT=4: issue 4 writers rd=1..4 -> 5th writer (rd=7) stalls with o_iss_ready=0. The 5th instruction with wr=0 and sources free -> accepted.
- LSU writeback rd=0, data=0x1234 -> o_lsu_ready=1, o_ce_wr=0, scoreboard unchanged.
- Assert i_rst_n=0 mid-stall with busy[3]=1 and a writeback pending -> busy cleared, o_rdata_valid=0, issue of rs1=3 accepted immediately after release.
